// File: rtl/gate_test_sequencer.sv
// Sequenced self-test checker for two-input gate cells: walks {a,b} through
// 00,01,10,11, waits a settle time, samples dut_y and counts truth-table mismatches.
module gate_test_sequencer #(
  parameter int         SETTLE_CYCLES = 2,
  parameter logic [3:0] EXPECT        = 4'b0110,
  parameter int         LOOPS         = 1,
  parameter int         CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_a,
  output logic             dut_b,
  input  logic             dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] err_count,
  output logic [3:0]       fail_vec
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]       LOOP_LAST   = 8'(LOOPS - 1);
  localparam logic [CNT_W-1:0] ERR_MAX     = '1;

  state_t state, next_state;

  logic [1:0]       vec, vec_d;
  logic [7:0]       loop_cnt, loop_d;
  logic [7:0]       settle_cnt, settle_d;
  logic             dut_a_d, dut_b_d;
  logic             busy_d, done_d, pass_d;
  logic [CNT_W-1:0] err_d;
  logic [3:0]       fail_d;
  logic             mismatch;

  // dut_y only matters in SAMPLE, so X or glitches elsewhere cannot count
  assign mismatch = (state == SAMPLE) && (dut_y != EXPECT[vec]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      loop_cnt   <= '0;
      settle_cnt <= '0;
      dut_a      <= 1'b0;
      dut_b      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_count  <= '0;
      fail_vec   <= '0;
    end else begin
      state      <= next_state;
      vec        <= vec_d;
      loop_cnt   <= loop_d;
      settle_cnt <= settle_d;
      dut_a      <= dut_a_d;
      dut_b      <= dut_b_d;
      busy       <= busy_d;
      done       <= done_d;
      pass       <= pass_d;
      err_count  <= err_d;
      fail_vec   <= fail_d;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (settle_cnt == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  if (vec != 2'd3 || loop_cnt != LOOP_LAST) next_state = SETTLE;
               else next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    vec_d    = vec;
    loop_d   = loop_cnt;
    settle_d = settle_cnt;
    dut_a_d  = dut_a;
    dut_b_d  = dut_b;
    err_d    = err_count;
    fail_d   = fail_vec;
    pass_d   = pass;
    case (state)
      IDLE: begin
        if (start) begin
          vec_d    = '0;
          loop_d   = '0;
          settle_d = '0;
          err_d    = '0;
          fail_d   = '0;
          pass_d   = 1'b0;
          dut_a_d  = 1'b0;
          dut_b_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (settle_cnt != SETTLE_LAST) settle_d = settle_cnt + 8'd1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_count != ERR_MAX) err_d = err_count + 1'b1;
          fail_d[vec] = 1'b1;
        end
        settle_d = '0;
        if (vec != 2'd3) begin
          vec_d   = vec + 2'd1;
          dut_a_d = vec_d[1];
          dut_b_d = vec_d[0];
        end else begin
          vec_d   = '0;
          dut_a_d = 1'b0;
          dut_b_d = 1'b0;
          if (loop_cnt != LOOP_LAST) loop_d = loop_cnt + 8'd1;
        end
      end
      default: ;
    endcase
    // pass must reflect a mismatch caught in the final SAMPLE cycle too
    if (next_state == DONE) pass_d = (err_d == '0);
    busy_d = (next_state == SETTLE) || (next_state == SAMPLE);
    done_d = (next_state == DONE);
  end

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: three instances cover default,
// multi-loop and narrow-counter configurations against modelled gate cells.
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  logic y0, y1, y2;
  logic a0, b0, busy0, done0, pass0;
  logic a1, b1, busy1, done1, pass1;
  logic a2, b2, busy2, done2, pass2;
  logic [7:0] err0, err1;
  logic [1:0] err2;
  logic [3:0] fv0, fv1, fv2;
  int mode0, mode1, mode2;
  logic xinj;
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Gate models: 0 XOR, 1 stuck-0, 2 XNOR, 3 stuck-1
  function automatic logic gate(input int mode, input logic a, input logic b);
    case (mode)
      0: return a ^ b;
      1: return 1'b0;
      2: return ~(a ^ b);
      default: return 1'b1;
    endcase
  endfunction

  assign y0 = xinj ? 1'bx : gate(mode0, a0, b0);
  assign y1 = gate(mode1, a1, b1);
  assign y2 = gate(mode2, a2, b2);

  gate_test_sequencer u0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(a0), .dut_b(b0), .dut_y(y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0), .fail_vec(fv0)
  );

  gate_test_sequencer #(.LOOPS(3)) u1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(a1), .dut_b(b1), .dut_y(y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .fail_vec(fv1)
  );

  gate_test_sequencer #(.CNT_W(2), .LOOPS(2)) u2 (
    .clk(clk), .rst(rst), .start(start2), .dut_a(a2), .dut_b(b2), .dut_y(y2),
    .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .fail_vec(fv2)
  );

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Runs one default-config pass on u0; the cycle after edge k is a SAMPLE cycle when k%3==2
  task automatic apply_stimulus(input string tag, input logic [7:0] exp_err,
                                input logic [3:0] exp_fv, input logic exp_pass);
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    check_output({tag, " busy@0"}, 32'(busy0), 32'd1);
    check_output({tag, " pass cleared"}, 32'(pass0), 32'd0);
    for (int k = 0; k < 12; k++) begin
      xinj = (k % 3) != 2;
      check_output({tag, " ab seq"}, 32'({a0, b0}), 32'(k / 3));
      check_output({tag, " no early done"}, 32'(done0), 32'd0);
      @(negedge clk);
    end
    xinj = 1'b0;
    check_output({tag, " done@12"}, 32'(done0), 32'd1);
    check_output({tag, " busy@12"}, 32'(busy0), 32'd0);
    check_output({tag, " pass"}, 32'(pass0), 32'(exp_pass));
    check_output({tag, " err_count"}, 32'(err0), 32'(exp_err));
    check_output({tag, " fail_vec"}, 32'(fv0), 32'(exp_fv));
    check_output({tag, " ab idle"}, 32'({a0, b0}), 32'd0);
    @(negedge clk);
    check_output({tag, " done pulse"}, 32'(done0), 32'd0);
    check_output({tag, " err held"}, 32'(err0), 32'(exp_err));
    check_output({tag, " pass held"}, 32'(pass0), 32'(exp_pass));
  endtask

  initial begin
    rst = 1'b1;
    start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mode0 = 0; mode1 = 3; mode2 = 2;
    xinj = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_output("reset busy", 32'(busy0), 32'd0);
    check_output("reset done", 32'(done0), 32'd0);
    check_output("reset pass", 32'(pass0), 32'd0);
    check_output("reset err", 32'(err0), 32'd0);
    check_output("reset fv", 32'(fv0), 32'd0);
    check_output("reset ab", 32'({a0, b0}), 32'd0);

    apply_stimulus("xor", 8'd0, 4'b0000, 1'b1);
    mode0 = 1;
    apply_stimulus("stuck0", 8'd2, 4'b0110, 1'b0);
    mode0 = 2;
    apply_stimulus("xnor", 8'd4, 4'b1111, 1'b0);

    // Async reset in the middle of vector 2's settle window
    mode0 = 1;
    @(negedge clk) start0 = 1'b1;
    @(negedge clk) start0 = 1'b0;
    repeat (6) @(negedge clk);
    check_output("pre-rst err", 32'(err0), 32'd1);
    check_output("pre-rst ab", 32'({a0, b0}), 32'd2);
    #2 rst = 1'b1;
    #1;
    check_output("async rst busy", 32'(busy0), 32'd0);
    check_output("async rst err", 32'(err0), 32'd0);
    check_output("async rst fv", 32'(fv0), 32'd0);
    check_output("async rst ab", 32'({a0, b0}), 32'd0);
    @(negedge clk) rst = 1'b0;
    mode0 = 0;
    apply_stimulus("post-rst", 8'd0, 4'b0000, 1'b1);

    // LOOPS=3, stuck-1, with stray start pulses mid-run
    @(negedge clk) start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    for (int k = 0; k < 36; k++) begin
      start1 = (k == 5 || k == 20);
      check_output("loops3 no early done", 32'(done1), 32'd0);
      if (k == 35) check_output("loops3 busy@35", 32'(busy1), 32'd1);
      @(negedge clk);
    end
    check_output("loops3 done@36", 32'(done1), 32'd1);
    check_output("loops3 err", 32'(err1), 32'd6);
    check_output("loops3 fv", 32'(fv1), 32'b1001);
    check_output("loops3 pass", 32'(pass1), 32'd0);
    start1 = 1'b1;
    @(negedge clk) start1 = 1'b0;
    check_output("loops3 start in DONE ignored", 32'(busy1), 32'd0);
    check_output("loops3 err held", 32'(err1), 32'd6);

    // CNT_W=2, LOOPS=2, XNOR: eight mismatches saturate at 3
    @(negedge clk) start2 = 1'b1;
    @(negedge clk) start2 = 1'b0;
    repeat (24) begin
      check_output("sat no early done", 32'(done2), 32'd0);
      @(negedge clk);
    end
    check_output("sat done@24", 32'(done2), 32'd1);
    check_output("sat err", 32'(err2), 32'd3);
    check_output("sat fv", 32'(fv2), 32'b1111);
    check_output("sat pass", 32'(pass2), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
